// File: rtl/alu_bus_pkg.sv
// Shared definitions for the ALU bus master slice.
// Holds the ALU register map, master FSM state encodings, the fixed bus script
// geometry, and a helper that maps a script index onto a Wishbone beat.
// Optional feature macro used by this slice: ALU_MASTER_TIMEOUT_EN.
package alu_bus_pkg;

   // ALU slave register map
   localparam logic [7:0] ALU_ADDR_A = 8'h00;
   localparam logic [7:0] ALU_ADDR_B = 8'h01;
   localparam logic [7:0] ALU_OP_ADD = 8'h80;
   localparam logic [7:0] ALU_OP_ADC = 8'h81;

   // Master FSM states
   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StIssue = 2'd1;
   localparam logic [1:0] StDrain = 2'd2;
   localparam logic [1:0] StResp  = 2'd3;

   // Bus script: write A, write B, read op, read op again
   localparam int unsigned SCRIPT_LEN  = 4;
   localparam logic [1:0]  LAST_IDX    = 2'(SCRIPT_LEN - 1);
   localparam logic [1:0]  CAPTURE_IDX = 2'd2;

   typedef struct packed {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
   } wb_beat_t;

   function automatic wb_beat_t script_beat(input logic [1:0] idx, input logic [7:0] op,
                                            input logic [7:0] a, input logic [7:0] b);
      wb_beat_t beat;
      case (idx)
         2'd0:    beat = '{we: 1'b1, addr: ALU_ADDR_A, data: a};
         2'd1:    beat = '{we: 1'b1, addr: ALU_ADDR_B, data: b};
         default: beat = '{we: 1'b0, addr: op, data: 8'h00};
      endcase
      return beat;
   endfunction

endpackage

// File: rtl/alu_master_timeout.sv
// Ack watchdog for the ALU bus master. Built only when ALU_MASTER_TIMEOUT_EN is defined.
// Ports:
//   i_clk     system clock
//   reset     asynchronous active-high reset
//   i_load    reload to TIMEOUT_CYCLES (request accept or ack)
//   i_run     bus cycle active, count down
//   o_expired counter hit zero while running
module alu_master_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic i_clk,
   input  logic reset,
   input  logic i_load,
   input  logic i_run,
   output logic o_expired
);

   localparam int unsigned    CntW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] Reload = CntW'(TIMEOUT_CYCLES);

   logic [CntW-1:0] cnt_q;

   always_ff @(posedge i_clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (i_load) begin
         cnt_q <= Reload;
      end else if (i_run && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CntW'(1);
      end
   end

   assign o_expired = i_run && (cnt_q == '0);

endmodule

// File: rtl/alu_bus_master.sv
// Wishbone pipelined master driving the ALU slave register interface.
// Takes one request (op, a, b), runs the script write A / write B / read op / read op,
// captures the third ack's data and returns it on a valid/ready response channel.
// Optional: define ALU_MASTER_TIMEOUT_EN to abort after TIMEOUT_CYCLES without an ack.
// Ports:
//   i_clk, reset                      clock, async active-high reset
//   i_req_valid/o_req_ready           request handshake (ready only when idle)
//   i_req_op/i_req_a/i_req_b          read address and the two operands
//   o_rsp_valid/i_rsp_ready           response handshake
//   o_rsp_data/o_rsp_err              captured result, timeout abort flag
//   o_wb_cyc/stb/we/addr/data         Wishbone master outputs
//   i_wb_ack/i_wb_stall/i_wb_data     Wishbone slave inputs
module alu_bus_master
   import alu_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic       i_clk,
   input  logic       reset,
   input  logic       i_req_valid,
   output logic       o_req_ready,
   input  logic [7:0] i_req_op,
   input  logic [7:0] i_req_a,
   input  logic [7:0] i_req_b,
   output logic       o_rsp_valid,
   input  logic       i_rsp_ready,
   output logic [7:0] o_rsp_data,
   output logic       o_rsp_err,
   output logic       o_wb_cyc,
   output logic       o_wb_stb,
   output logic       o_wb_we,
   output logic [7:0] o_wb_addr,
   output logic [7:0] o_wb_data,
   input  logic       i_wb_ack,
   input  logic       i_wb_stall,
   input  logic [7:0] i_wb_data
);

   logic [1:0] state_q, state_d;
   logic [1:0] issue_q, issue_d;
   logic [1:0] ack_q, ack_d;
   logic [7:0] op_q, op_d, a_q, a_d, b_q, b_d;
   logic [7:0] result_q, result_d;

   logic     busy, accept, stb, issue_fire, ack_fire, timeout_expired;
   wb_beat_t beat;

   assign busy       = (state_q == StIssue) || (state_q == StDrain);
   assign accept     = (state_q == StIdle) && i_req_valid;
   // An expiring watchdog drops cyc/stb in the same cycle it fires.
   assign stb        = (state_q == StIssue) && !timeout_expired;
   assign issue_fire = stb && !i_wb_stall;
   assign ack_fire   = busy && i_wb_ack && !timeout_expired;
   assign beat       = script_beat(issue_q, op_q, a_q, b_q);

   always_comb begin
      state_d  = state_q;
      issue_d  = issue_q;
      ack_d    = ack_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               op_d     = i_req_op;
               a_d      = i_req_a;
               b_d      = i_req_b;
               issue_d  = '0;
               ack_d    = '0;
               result_d = '0;
               state_d  = StIssue;
            end
         end
         StIssue, StDrain: begin
            if (issue_fire) begin
               issue_d = issue_q + 2'd1;
               if (issue_q == LAST_IDX) state_d = StDrain;
            end
            // Ack handling comes after issue so a final ack wins over ISSUE->DRAIN.
            if (ack_fire) begin
               ack_d = ack_q + 2'd1;
               if (ack_q == CAPTURE_IDX) result_d = i_wb_data;
               if (ack_q == LAST_IDX) state_d = StResp;
            end
            if (timeout_expired) begin
               result_d = '0;
               state_d  = StResp;
            end
         end
         default: begin
            if (i_rsp_ready) state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         issue_q  <= '0;
         ack_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         issue_q  <= issue_d;
         ack_q    <= ack_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
      end
   end

`ifdef ALU_MASTER_TIMEOUT_EN
   logic err_q;
   logic timeout_load;

   assign timeout_load = accept || (busy && i_wb_ack);

   alu_master_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .i_clk    (i_clk),
      .reset    (reset),
      .i_load   (timeout_load),
      .i_run    (busy),
      .o_expired(timeout_expired)
   );

   always_ff @(posedge i_clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= 1'b0;
      end else if (timeout_expired) begin
         err_q <= 1'b1;
      end
   end

   assign o_rsp_err = (state_q == StResp) && err_q;
`else
   assign timeout_expired = 1'b0;
   assign o_rsp_err       = 1'b0;
`endif

   assign o_req_ready = (state_q == StIdle);
   assign o_rsp_valid = (state_q == StResp);
   assign o_rsp_data  = (state_q == StResp) ? result_q : 8'h00;
   assign o_wb_cyc    = busy && !timeout_expired;
   assign o_wb_stb    = stb;
   assign o_wb_we     = stb && beat.we;
   assign o_wb_addr   = stb ? beat.addr : 8'h00;
   assign o_wb_data   = stb ? beat.data : 8'h00;

endmodule

// File: tb/tb_alu_bus_master.sv
// Self-checking bench for alu_bus_master with a behavioural ALU slave model.
module tb_alu_bus_master;

   logic       i_clk = 1'b0;
   logic       reset = 1'b1;
   logic       i_req_valid = 1'b0;
   logic       o_req_ready;
   logic [7:0] i_req_op = 8'h00, i_req_a = 8'h00, i_req_b = 8'h00;
   logic       o_rsp_valid;
   logic       i_rsp_ready = 1'b1;
   logic [7:0] o_rsp_data;
   logic       o_rsp_err;
   logic       o_wb_cyc, o_wb_stb, o_wb_we;
   logic [7:0] o_wb_addr, o_wb_data;
   logic       i_wb_ack = 1'b0, i_wb_stall = 1'b0;
   logic [7:0] i_wb_data = 8'h00;

   alu_bus_master #(
      .TIMEOUT_CYCLES(16)
   ) dut (
      .i_clk      (i_clk),
      .reset      (reset),
      .i_req_valid(i_req_valid),
      .o_req_ready(o_req_ready),
      .i_req_op   (i_req_op),
      .i_req_a    (i_req_a),
      .i_req_b    (i_req_b),
      .o_rsp_valid(o_rsp_valid),
      .i_rsp_ready(i_rsp_ready),
      .o_rsp_data (o_rsp_data),
      .o_rsp_err  (o_rsp_err),
      .o_wb_cyc   (o_wb_cyc),
      .o_wb_stb   (o_wb_stb),
      .o_wb_we    (o_wb_we),
      .o_wb_addr  (o_wb_addr),
      .o_wb_data  (o_wb_data),
      .i_wb_ack   (i_wb_ack),
      .i_wb_stall (i_wb_stall),
      .i_wb_data  (i_wb_data)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad = 0;

   // Slave model state
   logic [7:0]  slave_regs [0:1];
   logic [8:0]  owed_q [$];      // {is_read, addr} of issued beats awaiting ack
   logic [16:0] beat_q [$];      // {we, addr, write data or 0} per issued beat
   logic [16:0] prev_beat = '0;
   logic        prev_stalled = 1'b0;
   bit          ack_en = 1'b1;
   bit          rand_stall = 1'b0;
   int          stall_beat = -1;
   int          stall_left = 0;
   int          hold_viol = 0;
   int          cyc_high = 0;

   function automatic logic [7:0] slave_read(input logic [7:0] addr);
      case (addr)
         8'h00:   return slave_regs[0];
         8'h01:   return slave_regs[1];
         8'h80:   return slave_regs[0] + slave_regs[1];
         8'h81:   return slave_regs[0] + slave_regs[1] + 8'd1;
         default: return 8'hA5;
      endcase
   endfunction

   // What the ALU should return for op after A and B are written.
   function automatic logic [7:0] ref_result(input logic [7:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
      if (op == 8'h00) return a;
      if (op == 8'h01) return b;
      if (op == 8'h80) return 8'((int'(a) + int'(b)) % 256);
      return 8'((int'(a) + int'(b) + 1) % 256);
   endfunction

   // Advance one clock. Observes the bus before the edge, then drives slave inputs
   // after it: ack one cycle after issue, read data valid only while stb is high.
   task automatic tick();
      logic [16:0] cur;
      logic [8:0]  item;
      logic        issued;
      cur    = {o_wb_we, o_wb_addr, (o_wb_we ? o_wb_data : 8'h00)};
      issued = o_wb_cyc && o_wb_stb && !i_wb_stall;
      if (o_wb_stb && prev_stalled && (cur !== prev_beat)) hold_viol++;
      prev_stalled = o_wb_stb && i_wb_stall;
      prev_beat    = cur;
      if (o_wb_cyc) cyc_high++;
      if (issued) begin
         beat_q.push_back(cur);
         if (o_wb_we) slave_regs[o_wb_addr[0]] = o_wb_data;
         owed_q.push_back({!o_wb_we, o_wb_addr});
      end
      @(posedge i_clk);
      #1;
      item     = '0;
      i_wb_ack = 1'b0;
      if (ack_en && (owed_q.size() > 0)) begin
         item     = owed_q.pop_front();
         i_wb_ack = 1'b1;
      end
      i_wb_stall = 1'b0;
      if (o_wb_stb) begin
         if ((stall_left > 0) && (beat_q.size() == stall_beat)) begin
            i_wb_stall = 1'b1;
            stall_left--;
         end else if (rand_stall) begin
            i_wb_stall = ($urandom_range(0, 3) == 0);
         end
      end
      i_wb_data = (i_wb_ack && item[8] && o_wb_stb) ? slave_read(item[7:0]) : 8'($urandom);
      #1;
   endtask

   // Present a request in an idle cycle and run until o_rsp_valid (bounded).
   task automatic run_txn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic got, output int lat);
      beat_q.delete();
      hold_viol   = 0;
      cyc_high    = 0;
      i_req_op    = op;
      i_req_a     = a;
      i_req_b     = b;
      i_req_valid = 1'b1;
      tick();
      i_req_valid = 1'b0;
      lat = 1;
      while (!o_rsp_valid && (lat < 200)) begin
         tick();
         lat++;
      end
      got = o_rsp_valid;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge i_clk);
      #2;
      total++;
      if ({o_req_ready, o_rsp_valid, o_rsp_err, o_wb_cyc, o_wb_stb, o_wb_we} !== 6'b100000) begin
         bad++;
         $display("FAIL reset_ctrl: got %b want 100000",
                  {o_req_ready, o_rsp_valid, o_rsp_err, o_wb_cyc, o_wb_stb, o_wb_we});
      end
      total++;
      if ({o_rsp_data, o_wb_addr, o_wb_data} !== 24'h0) begin
         bad++;
         $display("FAIL reset_data: got %h want 000000", {o_rsp_data, o_wb_addr, o_wb_data});
      end
      reset = 1'b0;
      tick();
      total++;
      if (o_req_ready !== 1'b1 || o_wb_cyc !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: ready=%b cyc=%b want 1 0", o_req_ready, o_wb_cyc);
      end
   endtask

   task automatic check_beats(input string name, input logic [7:0] op, input logic [7:0] a,
                              input logic [7:0] b);
      logic [16:0] exp_b [4];
      exp_b[0] = {1'b1, 8'h00, a};
      exp_b[1] = {1'b1, 8'h01, b};
      exp_b[2] = {1'b0, op, 8'h00};
      exp_b[3] = {1'b0, op, 8'h00};
      total++;
      if (beat_q.size() != 4) begin
         bad++;
         $display("FAIL %s_beat_count: got %0d want 4", name, beat_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (beat_q[i] !== exp_b[i]) begin
               bad++;
               $display("FAIL %s_beat%0d: got %h want %h", name, i, beat_q[i], exp_b[i]);
            end
         end
      end
   endtask

   task automatic test_basic();
      logic got;
      int   lat;
      run_txn(8'h00, 8'h5A, 8'hC3, got, lat);
      total++;
      if (lat !== 6) begin
         bad++;
         $display("FAIL basic_latency: got %0d want 6", lat);
      end
      total++;
      if ({got, o_rsp_data, o_rsp_err} !== {1'b1, 8'h5A, 1'b0}) begin
         bad++;
         $display("FAIL basic_rsp: got v=%b d=%h e=%b want 1 5a 0", got, o_rsp_data, o_rsp_err);
      end
      tick();
      check_beats("basic", 8'h00, 8'h5A, 8'hC3);
   endtask

   task automatic test_stall();
      logic got;
      int   lat;
      stall_beat = 1;
      stall_left = 3;
      run_txn(8'h01, 8'h11, 8'hC3, got, lat);
      stall_beat = -1;
      total++;
      if (lat !== 9) begin
         bad++;
         $display("FAIL stall_latency: got %0d want 9", lat);
      end
      total++;
      if ({got, o_rsp_data, o_rsp_err} !== {1'b1, 8'hC3, 1'b0}) begin
         bad++;
         $display("FAIL stall_rsp: got v=%b d=%h e=%b want 1 c3 0", got, o_rsp_data, o_rsp_err);
      end
      total++;
      if (hold_viol !== 0) begin
         bad++;
         $display("FAIL stall_hold: got %0d changes want 0", hold_viol);
      end
      tick();
      check_beats("stall", 8'h01, 8'h11, 8'hC3);
   endtask

   task automatic test_backpressure();
      logic       got;
      int         lat;
      logic [7:0] exp;
      exp = ref_result(8'h80, 8'h3C, 8'hD9);
      i_rsp_ready = 1'b0;
      run_txn(8'h80, 8'h3C, 8'hD9, got, lat);
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if ({o_rsp_valid, o_rsp_data, o_req_ready, o_wb_cyc, o_wb_stb} !==
             {1'b1, exp, 3'b000}) begin
            bad++;
            $display("FAIL bp_hold%0d: got v=%b d=%h rdy=%b cyc=%b stb=%b want 1 %h 0 0 0", i,
                     o_rsp_valid, o_rsp_data, o_req_ready, o_wb_cyc, o_wb_stb, exp);
         end
      end
      // Handshake cycle: a new request is already waiting but must not be taken yet.
      i_rsp_ready = 1'b1;
      i_req_valid = 1'b1;
      #1;
      total++;
      if (o_req_ready !== 1'b0) begin
         bad++;
         $display("FAIL bp_same_cycle_ready: got %b want 0", o_req_ready);
      end
      tick();
      total++;
      if ({o_req_ready, o_rsp_valid} !== 2'b10) begin
         bad++;
         $display("FAIL bp_after_hs: got rdy=%b v=%b want 1 0", o_req_ready, o_rsp_valid);
      end
      run_txn(8'h81, 8'hFF, 8'h01, got, lat);
      total++;
      if ({got, o_rsp_data, lat} !== {1'b1, ref_result(8'h81, 8'hFF, 8'h01), 6}) begin
         bad++;
         $display("FAIL bp_next: got v=%b d=%h lat=%0d want 1 %h 6", got, o_rsp_data, lat,
                  ref_result(8'h81, 8'hFF, 8'h01));
      end
      tick();
   endtask

   task automatic test_reset_mid();
      logic got;
      int   lat;
      int   n;
      beat_q.delete();
      i_req_op    = 8'h80;
      i_req_a     = 8'h12;
      i_req_b     = 8'h34;
      i_req_valid = 1'b1;
      tick();
      i_req_valid = 1'b0;
      n = 0;
      while (!(o_wb_stb && !o_wb_we && beat_q.size() == 2) && n < 50) begin
         tick();
         n++;
      end
      reset = 1'b1;
      #1;
      total++;
      if ({o_wb_cyc, o_wb_stb, o_rsp_valid, o_req_ready} !== 4'b0001 || n >= 50) begin
         bad++;
         $display("FAIL reset_mid: got cyc=%b stb=%b v=%b rdy=%b wait=%0d want 0 0 0 1",
                  o_wb_cyc, o_wb_stb, o_rsp_valid, o_req_ready, n);
      end
      owed_q.delete();
      i_wb_ack     = 1'b0;
      prev_stalled = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      total++;
      if (o_rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_no_rsp: got v=%b want 0", o_rsp_valid);
      end
      run_txn(8'h00, 8'h77, 8'h01, got, lat);
      total++;
      if ({got, o_rsp_data} !== {1'b1, 8'h77}) begin
         bad++;
         $display("FAIL reset_mid_next: got v=%b d=%h want 1 77", got, o_rsp_data);
      end
      tick();
   endtask

   task automatic test_no_ack();
      logic got;
      int   lat;
      ack_en = 1'b0;
`ifdef ALU_MASTER_TIMEOUT_EN
      run_txn(8'h80, 8'h21, 8'h43, got, lat);
      total++;
      if ({got, o_rsp_err, o_rsp_data} !== {1'b1, 1'b1, 8'h00}) begin
         bad++;
         $display("FAIL timeout_rsp: got v=%b e=%b d=%h want 1 1 00", got, o_rsp_err, o_rsp_data);
      end
      total++;
      if (cyc_high !== 16) begin
         bad++;
         $display("FAIL timeout_cyc_len: got %0d want 16", cyc_high);
      end
      owed_q.delete();
      ack_en = 1'b1;
      tick();
`else
      beat_q.delete();
      i_req_op    = 8'h80;
      i_req_a     = 8'h21;
      i_req_b     = 8'h43;
      i_req_valid = 1'b1;
      tick();
      i_req_valid = 1'b0;
      repeat (40) tick();
      total++;
      if ({o_wb_cyc, o_rsp_valid, o_rsp_err} !== 3'b100) begin
         bad++;
         $display("FAIL wait_no_ack: got cyc=%b v=%b e=%b want 1 0 0", o_wb_cyc, o_rsp_valid,
                  o_rsp_err);
      end
      ack_en = 1'b1;
      lat = 0;
      while (!o_rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      got = o_rsp_valid;
      total++;
      if ({got, o_rsp_err} !== 2'b10) begin
         bad++;
         $display("FAIL wait_completes: got v=%b e=%b want 1 0", got, o_rsp_err);
      end
      tick();
`endif
   endtask

   task automatic test_stray_ack();
      logic got;
      int   lat;
      i_wb_ack  = 1'b1;
      i_wb_data = 8'h99;
      repeat (2) @(posedge i_clk);
      #2;
      i_wb_ack = 1'b0;
      total++;
      if ({o_req_ready, o_wb_cyc, o_rsp_valid} !== 3'b100) begin
         bad++;
         $display("FAIL stray_idle: got rdy=%b cyc=%b v=%b want 1 0 0", o_req_ready, o_wb_cyc,
                  o_rsp_valid);
      end
      run_txn(8'h01, 8'h0F, 8'hE4, got, lat);
      total++;
      if ({got, o_rsp_data, lat} !== {1'b1, 8'hE4, 6}) begin
         bad++;
         $display("FAIL stray_next: got v=%b d=%h lat=%0d want 1 e4 6", got, o_rsp_data, lat);
      end
      tick();
   endtask

   task automatic test_random();
      logic [7:0] ops [4];
      logic [7:0] op, a, b, exp;
      logic       got;
      int         lat, delay;
      ops[0] = 8'h00;
      ops[1] = 8'h01;
      ops[2] = 8'h80;
      ops[3] = 8'h81;
      rand_stall = 1'b1;
      for (int t = 0; t < 16; t++) begin
         op    = ops[$urandom_range(0, 3)];
         a     = 8'($urandom);
         b     = 8'($urandom);
         exp   = ref_result(op, a, b);
         delay = $urandom_range(0, 2);
         i_rsp_ready = (delay == 0);
         run_txn(op, a, b, got, lat);
         total++;
         if ({got, o_rsp_data, o_rsp_err} !== {1'b1, exp, 1'b0}) begin
            bad++;
            $display("FAIL rand%0d_rsp: op=%h a=%h b=%h got v=%b d=%h e=%b want 1 %h 0", t, op, a,
                     b, got, o_rsp_data, o_rsp_err, exp);
         end
         total++;
         if (hold_viol !== 0) begin
            bad++;
            $display("FAIL rand%0d_hold: got %0d changes want 0", t, hold_viol);
         end
         repeat (delay) tick();
         i_rsp_ready = 1'b1;
         tick();
         check_beats("rand", op, a, b);
      end
      rand_stall = 1'b0;
      i_wb_stall = 1'b0;
   endtask

   initial begin
      slave_regs[0] = 8'h00;
      slave_regs[1] = 8'h00;
      test_reset();
      test_basic();
      test_stall();
      test_backpressure();
      test_reset_mid();
      test_no_ack();
      test_stray_ack();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
